// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter with a one-deep hold buffer.
// Words are shifted out back-to-back, one bit per clock, with valid and first-bit strobes.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] p_in_i,
    input  logic             p_valid_i,
    output logic             p_ready_o,
    output logic             s_out_o,
    output logic             s_valid_o,
    output logic             s_first_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic [WIDTH-1:0] sreg_shift_d;

    assign accept = p_valid_i && !hold_full_q;

    // The shift always moves toward the output end, zero-filling behind.
    always_comb begin
        if (MSB_FIRST) begin
            sreg_shift_d = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shift_d = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sreg_q  <= p_in_i;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != LAST) begin
                        sreg_q <= sreg_shift_d;
                        cnt_q  <= cnt_q + CW'(1);
                        if (accept) begin
                            hold_q      <= p_in_i;
                            hold_full_q <= 1'b1;
                        end
                    // On the last bit a held word wins over a bypass; p_ready is low then anyway.
                    end else if (hold_full_q) begin
                        sreg_q      <= hold_q;
                        hold_full_q <= 1'b0;
                        cnt_q       <= '0;
                    end else if (accept) begin
                        sreg_q <= p_in_i;
                        cnt_q  <= '0;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign p_ready_o = !hold_full_q;
    assign s_out_o   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign s_valid_o = (state_q == SHIFT);
    assign s_first_o = (state_q == SHIFT) && (cnt_q == '0);
    assign busy_o    = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: vector table for single/back-to-back/bypass traffic,
// plus hand sequences for reset behaviour and LSB-first ordering.
module tb_piso_tx;

    logic       clk;
    logic       rst_n;
    logic [3:0] pIn;
    logic       pValid;
    logic       pReady;
    logic       sOut;
    logic       sValid;
    logic       sFirst;
    logic       busy;

    logic [3:0] pIn2;
    logic       pValid2;
    logic       pReady2;
    logic       sOut2;
    logic       sValid2;
    logic       sFirst2;
    logic       busy2;

    int total;
    int bad;

    typedef struct {
        logic       pv;
        logic [3:0] pin;
        logic       sv;
        logic       sf;
        logic       so;
        logic       pr;
        logic       bz;
    } vec_t;

    vec_t vecs[24];

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dutMsb (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .p_in_i   (pIn),
        .p_valid_i(pValid),
        .p_ready_o(pReady),
        .s_out_o  (sOut),
        .s_valid_o(sValid),
        .s_first_o(sFirst),
        .busy_o   (busy)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dutLsb (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .p_in_i   (pIn2),
        .p_valid_i(pValid2),
        .p_ready_o(pReady2),
        .s_out_o  (sOut2),
        .s_valid_o(sValid2),
        .s_first_o(sFirst2),
        .busy_o   (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic pv, input logic [3:0] pin, input logic sv,
                                input logic sf, input logic so, input logic pr, input logic bz);
        vec_t v;
        v.pv  = pv;
        v.pin = pin;
        v.sv  = sv;
        v.sf  = sf;
        v.so  = so;
        v.pr  = pr;
        v.bz  = bz;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge so the rising edge always sees them settled.
    task automatic applyStimulus(input logic pv, input logic [3:0] pin);
        @(negedge clk);
        pValid = pv;
        pIn    = pin;
    endtask

    task automatic checkMsb(input string tag, input logic sv, input logic sf, input logic so,
                            input logic pr, input logic bz);
        checkOutput({tag, ".s_valid"}, sValid, sv);
        checkOutput({tag, ".s_first"}, sFirst, sf);
        checkOutput({tag, ".s_out"},   sOut,   so);
        checkOutput({tag, ".p_ready"}, pReady, pr);
        checkOutput({tag, ".busy"},    busy,   bz);
    endtask

    initial begin
        logic [3:0] lsbExp;
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        pValid  = 1'b1;
        pIn     = 4'hF;
        pValid2 = 1'b1;
        pIn2    = 4'hF;

        // Single word 1011, then idle.
        vecs[0]  = mk(1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[1]  = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[2]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[3]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[4]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        // Back-to-back A then 5 through the hold buffer.
        vecs[5]  = mk(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[7]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[11] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[12] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[13] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        // Bypass: C, then 3 offered only in the last-bit cycle.
        vecs[14] = mk(1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[15] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[16] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[17] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[18] = mk(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[19] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[20] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[21] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[22] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[23] = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset held for three cycles with p_valid high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkMsb($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("rst%0d.lsb_valid", i), sValid2, 1'b0);
        end
        rst_n   = 1'b1;
        pValid  = 1'b0;
        pValid2 = 1'b0;
        pIn2    = 4'h0;

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].pv, vecs[i].pin);
            checkMsb($sformatf("v%0d", i), vecs[i].sv, vecs[i].sf, vecs[i].so,
                     vecs[i].pr, vecs[i].bz);
        end

        // Reset mid-word while a second word sits in hold.
        applyStimulus(1'b1, 4'hF);
        applyStimulus(1'b1, 4'h5);
        checkMsb("mid1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'h0);
        checkMsb("mid2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1 checkMsb("midrst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkMsb($sformatf("post%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // LSB-first ordering of 0001.
        @(negedge clk);
        pValid2 = 1'b1;
        pIn2    = 4'b0001;
        lsbExp  = 4'b0001;
        @(negedge clk);
        pValid2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("lsb%0d.s_out", i), sOut2, lsbExp[i]);
            checkOutput($sformatf("lsb%0d.s_valid", i), sValid2, 1'b1);
            checkOutput($sformatf("lsb%0d.s_first", i), sFirst2, (i == 0));
            @(negedge clk);
        end
        checkOutput("lsbEnd.s_valid", sValid2, 1'b0);
        checkOutput("lsbEnd.busy", busy2, 1'b0);
        checkOutput("lsbEnd.p_ready", pReady2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parameterised parallel-in/serial-out transmitter. It accepts words over a valid/ready handshake, holds one word in a buffer, and shifts each word out one bit per clock with a valid strobe and a first-bit marker. Words are sent back-to-back with no idle cycle between them. It is the transmit end of the team's serial link. With MSB-first order, a downstream shift-left deserializer (new bit enters at LSB) rebuilds the original word after WIDTH bits.

## Interface
- WIDTH, 4, word width in bits; must be ≥2.
- MSB_FIRST, 1, bit order. 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. Asserting it clears all state at once; release is sampled on clk.
- p_in  input  WIDTH  parallel word; sampled on an accept edge.
- p_valid  input  1  p_in is valid.
- p_ready  output  1  block can take a word. Equals !hold_full, driven from a register.
- s_out  output  1  serial data. Equals sreg[WIDTH-1] (MSB_FIRST=1) or sreg[0] (MSB_FIRST=0).
- s_valid  output  1  s_out carries a payload bit this cycle. High exactly when state==SHIFT.
- s_first  output  1  s_valid && cnt==0; marks the first bit of each word.
- busy  output  1  state==SHIFT || hold_full.

## Operation
- Storage:
  - sreg[WIDTH-1:0], the shift register.
  - hold[WIDTH-1:0] plus hold_full, a one-deep buffer.
  - cnt, a bit counter, $clog2(WIDTH) bits.
  - state, one of IDLE or SHIFT.
- Accept means p_valid && p_ready at a rising edge. p_in is not sampled on any other edge.
- IDLE:
  - On accept: sreg<=p_in, cnt<=0, state<=SHIFT.
  - Without accept: nothing changes; s_out stays at the value left in sreg.
- SHIFT, not the last bit (cnt<WIDTH-1):
  - Shift toward the output end and fill with 0: left shift when MSB_FIRST=1, right shift otherwise.
  - cnt<=cnt+1.
  - On accept: hold<=p_in, hold_full<=1.
- SHIFT, last bit (cnt==WIDTH-1), in priority order:
  1. hold_full=1: sreg<=hold, hold_full<=0, cnt<=0, stay in SHIFT. p_ready=0 this cycle, so no accept can occur.
  2. Accept this cycle (hold empty): sreg<=p_in directly (bypass), cnt<=0, stay in SHIFT. hold is not written.
  3. Otherwise: state<=IDLE, cnt<=0.
- No word is ever dropped or duplicated. p_valid while p_ready=0 has no effect, and the source must hold p_in stable until the accept.
- Reset (rst=0): sreg=0, hold=0, hold_full=0, cnt=0, state=IDLE.
  - Outputs are s_out=0, s_valid=0, s_first=0, busy=0, p_ready=1.
  - A word partly sent when reset asserts is truncated, and any held word is discarded.

## Timing
- Latency: a word accepted at edge N shows its first bit on s_out (with s_valid and s_first high) in the cycle after edge N. Its last bit is in the cycle after edge N+WIDTH-1.
- Each word occupies exactly WIDTH consecutive s_valid cycles.
- Sustained throughput is one word every WIDTH cycles with no gaps, provided the next word is accepted no later than the last-bit cycle of the current word.
- p_ready:
  - Falls the cycle after a word is written into hold.
  - Rises the cycle after the last-bit edge that moves hold into sreg.
- After the final word, s_valid drops in the cycle after that word's last bit, and busy drops at the same time.
- All outputs are functions of registers only; there is no combinational path from p_valid or p_in to any output.
- A reset release coinciding with a clk edge must not cause an accept on that edge. Only edges with rst=1 both before and at the edge count.

## Test plan
- Reset: hold rst=0 for 3 cycles with p_valid=1 → s_valid=0, s_out=0, busy=0, p_ready=1; no word is accepted.
- Single word, WIDTH=4: accept 4'b1011 at edge 0 → cycles 1-4 give s_out=1,0,1,1. s_valid is high for those 4 cycles and s_first only in cycle 1. Cycle 5: s_valid=0, busy=0.
- Back-to-back: 4'hA accepted at edge 0, with 4'h5 offered from cycle 1 → 4'h5 goes into hold at edge 1 and p_ready=0 in cycles 2-4. s_out is 1,0,1,0,0,1,0,1 over cycles 1-8 with no gap, and s_first is high in cycles 1 and 5.
- Bypass: 4'hC accepted at edge 0, then 4'h3 offered only in cycle 4 (the last-bit cycle) → it loads straight into sreg. s_out is 1,1,0,0,0,0,1,1 over cycles 1-8 and hold_full is never set.
- Reset mid-word: accept 4'hF, drop rst after 2 output bits while a second word sits in hold → s_valid=0 immediately. After release: p_ready=1, busy=0, and no stale bits appear.
- Bit order: MSB_FIRST=0, accept 4'b0001 → s_out=1,0,0,0 over cycles 1-4.
